// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
//   loader_state_t    : frame-parser state encoding
//   SYNC_BYTE_DEFAULT : default frame start marker
//   imem_word_t       : one 32-bit instruction word
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef logic [31:0] imem_word_t;

endpackage

// File: rtl/loader_word_assembler.sv
// Little-endian byte-to-word assembler for the boot loader.
// The first byte of a word lands in word_o[7:0]. word_vld_o is asserted
// combinationally on the cycle the 4th byte is presented, with word_o
// already holding the complete word, so the parent can register the
// write in the same edge that consumes the byte.
//   clk, rst    : clock, asynchronous active-high reset
//   byte_vld_i  : byte strobe
//   byte_i      : byte value
//   clr_i       : restart byte alignment at byte 0
//   word_o      : assembled word (valid while word_vld_o=1)
//   word_vld_o  : 4th byte of a word is being presented
module loader_word_assembler
    import loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_vld_i,
    input  logic [7:0] byte_i,
    input  logic       clr_i,
    output imem_word_t word_o,
    output logic       word_vld_o
);

    // Only three bytes need storage; the 4th is taken straight from byte_i.
    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clr_i) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (byte_vld_i) begin
            shift_d = {byte_i, shift_q[23:8]};
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign word_o     = {byte_i, shift_q};
    assign word_vld_o = byte_vld_i && (idx_q == 2'd3);

endmodule

// File: rtl/uart_imem_loader.sv
// UART boot loader: parses frames of
//   SYNC_BYTE, len[7:0], len[15:8], len x (4 bytes little-endian), XOR checksum
// and writes each word into the instruction memory. The CPU is held in
// reset (cpu_hold=1) until a frame completes with a matching checksum.
// Optional inter-byte timeout: define LOADER_TIMEOUT_EN.
//   clk, rst     : clock, asynchronous active-high reset
//   rx_valid     : one-cycle byte strobe from UART RX
//   rx_data      : received byte
//   imem_we      : one-cycle write strobe
//   imem_waddr   : byte address of the word being written
//   imem_wdata   : word being written
//   cpu_hold     : core reset hold
//   load_done    : last frame loaded with good checksum
//   load_err     : last frame failed (oversize, checksum, timeout)
//   words_loaded : words written in current/last frame
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  imem_we,
    output logic [31:0]           imem_waddr,
    output imem_word_t            imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    loader_state_t         state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
    logic                  we_q, we_d;
    logic [31:0]           waddr_q, waddr_d;
    imem_word_t            wdata_q, wdata_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  asm_clr;
    logic                  asm_stb;
    logic                  word_cmp;
    imem_word_t            asm_word;
    logic                  is_sync;
    logic [15:0]           new_len;
    logic                  timeout_hit;

    assign is_sync = rx_valid && (rx_data == SYNC_BYTE);
    assign new_len = {rx_data, len_q[7:0]};
    assign asm_stb = rx_valid && (state_q == S_DATA);

    loader_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_vld_i (asm_stb),
        .byte_i     (rx_data),
        .clr_i      (asm_clr),
        .word_o     (asm_word),
        .word_vld_o (word_cmp)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    // Saturating idle counter, restarted by every received byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (rx_valid) begin
            tmo_q <= '0;
        end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign timeout_hit = !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES)) &&
                         ((state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                          (state_q == S_DATA)   || (state_q == S_CHECK));
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        csum_d  = csum_q;
        wcnt_d  = wcnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        asm_clr = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (is_sync) begin
                    state_d = S_LEN_LO;
                    csum_d  = '0;
                    wcnt_d  = '0;
                    asm_clr = 1'b1;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    len_d = new_len;
                    if (32'(new_len) > (32'd1 << ADDR_WIDTH)) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else if (new_len == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    csum_d = csum_q ^ rx_data;
                    if (word_cmp) begin
                        we_d    = 1'b1;
                        wdata_d = asm_word;
                        waddr_d = {{(32-ADDR_WIDTH-3){1'b0}}, wcnt_q, 2'b00};
                        wcnt_d  = wcnt_q + 1'b1;
                        if ((16'(wcnt_q) + 16'd1) == len_q) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A stalled frame is abandoned; only reachable in active parse states.
        if (timeout_hit) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            csum_q  <= '0;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = wcnt_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: table vectors, hand-written corner sequences
// and random frames checked against a frame-level reference model.
module tb_uart_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          imem_we;
    logic [31:0]   imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_loaded;

    always #5 clk = ~clk;

    uart_imem_loader #(
        .ADDR_WIDTH     (AW),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [95:0] b;      // bytes, first byte in [95:88]
        int          n;
        int          nw;
        logic [31:0] a0, d0, a1, d1;
        bit          done, err, hold;
        int          wl;
    } vec_t;

    wr_t wq[$];
    int  checks = 0;
    int  errors = 0;

    // Every cycle with a write strobe is logged, so a stretched pulse shows up
    // as an extra entry.
    always @(negedge clk) begin
        if (imem_we) wq.push_back('{a: imem_waddr, d: imem_wdata});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_flags(input string name, input bit done, input bit err, input int wl);
        chk({name, ".load_done"}, 64'(load_done), 64'(done));
        chk({name, ".load_err"}, 64'(load_err), 64'(err));
        chk({name, ".cpu_hold"}, 64'(cpu_hold), 64'(!done));
        chk({name, ".words_loaded"}, 64'(words_loaded), 64'(wl));
    endtask

    task automatic check_writes(input string name, input wr_t ew[$]);
        chk({name, ".nwrites"}, 64'(wq.size()), 64'(ew.size()));
        for (int i = 0; i < ew.size() && i < wq.size(); i++) begin
            chk($sformatf("%s.waddr%0d", name, i), 64'(wq[i].a), 64'(ew[i].a));
            chk($sformatf("%s.wdata%0d", name, i), 64'(wq[i].d), 64'(ew[i].d));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, ".imem_we"}, 64'(imem_we), 64'(0));
        chk({name, ".imem_waddr"}, 64'(imem_waddr), 64'(0));
        chk({name, ".imem_wdata"}, 64'(imem_wdata), 64'(0));
        chk({name, ".cpu_hold"}, 64'(cpu_hold), 64'(1));
        chk({name, ".load_done"}, 64'(load_done), 64'(0));
        chk({name, ".load_err"}, 64'(load_err), 64'(0));
        chk({name, ".words_loaded"}, 64'(words_loaded), 64'(0));
    endtask

    // Frame-level reference: parse the byte list directly from the frame rules.
    task automatic model(input logic [7:0] f[$], output wr_t ew[$],
                         output bit done, output bit err, output int wl);
        int          len;
        logic [7:0]  cs;
        ew  = {};
        cs  = 8'h00;
        len = int'(f[1]) + 256 * int'(f[2]);
        if (len > (1 << AW)) begin
            done = 1'b0;
            err  = 1'b1;
            wl   = 0;
            return;
        end
        for (int i = 0; i < len; i++) begin
            wr_t w;
            w.a = 32'(4 * i);
            w.d = {f[3+4*i+3], f[3+4*i+2], f[3+4*i+1], f[3+4*i]};
            ew.push_back(w);
            for (int k = 0; k < 4; k++) cs ^= f[3+4*i+k];
        end
        wl   = len;
        done = (f[3+4*len] == cs);
        err  = !done;
    endtask

    vec_t vt[4];

    initial begin
        wr_t        ew[$];
        logic [7:0] f[$];
        bit         m_done, m_err;
        int         m_wl;

        // Checksum of the two-word image: 13 ^ 93 ^ 10 = 90.
        vt[0] = '{b: {8'hA5,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00,8'h90},
                  n: 12, nw: 2, a0: 32'h0, d0: 32'h00000013, a1: 32'h4, d1: 32'h00100093,
                  done: 1, err: 0, hold: 0, wl: 2};
        vt[1] = '{b: {8'hA5,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00,8'h91},
                  n: 12, nw: 2, a0: 32'h0, d0: 32'h00000013, a1: 32'h4, d1: 32'h00100093,
                  done: 0, err: 1, hold: 1, wl: 2};
        vt[2] = '{b: {8'hA5,8'h01,8'h04,72'h0},
                  n: 3, nw: 0, a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0,
                  done: 0, err: 1, hold: 1, wl: 0};
        vt[3] = '{b: {8'hA5,8'h00,8'h00,8'h00,64'h0},
                  n: 4, nw: 0, a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0,
                  done: 1, err: 0, hold: 0, wl: 0};

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Table vectors, back to back, no reset in between.
        for (int v = 0; v < 4; v++) begin
            wq = {};
            for (int i = 0; i < vt[v].n; i++) send(vt[v].b[95-8*i -: 8], 0);
            chk($sformatf("vec%0d.nwrites", v), 64'(wq.size()), 64'(vt[v].nw));
            if (vt[v].nw >= 1 && wq.size() >= 1) begin
                chk($sformatf("vec%0d.waddr0", v), 64'(wq[0].a), 64'(vt[v].a0));
                chk($sformatf("vec%0d.wdata0", v), 64'(wq[0].d), 64'(vt[v].d0));
            end
            if (vt[v].nw >= 2 && wq.size() >= 2) begin
                chk($sformatf("vec%0d.waddr1", v), 64'(wq[1].a), 64'(vt[v].a1));
                chk($sformatf("vec%0d.wdata1", v), 64'(wq[1].d), 64'(vt[v].d1));
            end
            chk($sformatf("vec%0d.load_done", v), 64'(load_done), 64'(vt[v].done));
            chk($sformatf("vec%0d.load_err", v), 64'(load_err), 64'(vt[v].err));
            chk($sformatf("vec%0d.cpu_hold", v), 64'(cpu_hold), 64'(vt[v].hold));
            chk($sformatf("vec%0d.words_loaded", v), 64'(words_loaded), 64'(vt[v].wl));
        end

        // Restart from DONE re-asserts the hold.
        send(8'hA5, 0);
        chk("restart.cpu_hold", 64'(cpu_hold), 64'(1));
        chk("restart.load_done", 64'(load_done), 64'(0));

        // Mid-frame asynchronous reset after two data bytes of word 0.
        wq = {};
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'h13, 0);
        send(8'h00, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        f = '{8'hA5, 8'h01, 8'h00, 8'h37, 8'h02, 8'h00, 8'h00, 8'h35};
        foreach (f[i]) send(f[i], 0);
        ew = '{'{a: 32'h0, d: 32'h00000237}};
        check_writes("after_rst", ew);
        check_flags("after_rst", 1'b1, 1'b0, 1);

        // Asynchronous reset from DONE takes effect without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("done_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stall inside a frame after the low length byte.
        wq = {};
        send(8'hA5, 0);
        send(8'h01, 0);
        repeat (150) begin
            @(posedge clk);
            #1;
        end
`ifdef LOADER_TIMEOUT_EN
        chk("timeout.load_err", 64'(load_err), 64'(1));
        chk("timeout.cpu_hold", 64'(cpu_hold), 64'(1));
        chk("timeout.nwrites", 64'(wq.size()), 64'(0));
`else
        chk("stall.load_err", 64'(load_err), 64'(0));
        chk("stall.cpu_hold", 64'(cpu_hold), 64'(1));
        // Still waiting for the high length byte: finish the frame.
        f = '{8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
        foreach (f[i]) send(f[i], 0);
        ew = '{'{a: 32'h0, d: 32'h11223344}};
        check_writes("stall", ew);
        check_flags("stall", 1'b1, 1'b0, 1);
`endif

        // Random frames with random inter-byte gaps.
        for (int fr = 0; fr < 30; fr++) begin
            int         len;
            logic [7:0] x;
            logic [7:0] g;
            wq = {};
            if ($urandom_range(0, 3) == 0) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                send(g, $urandom_range(0, 2));
            end
            f = {};
            f.push_back(8'hA5);
            if ($urandom_range(0, 7) == 0) len = $urandom_range(1025, 65535);
            else len = $urandom_range(0, 5);
            f.push_back(8'(len));
            f.push_back(8'(len >> 8));
            if (len <= (1 << AW)) begin
                x = 8'h00;
                for (int i = 0; i < 4 * len; i++) begin
                    logic [7:0] r;
                    r = 8'($urandom_range(0, 255));
                    x ^= r;
                    f.push_back(r);
                end
                if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
                f.push_back(x);
            end
            foreach (f[i]) send(f[i], $urandom_range(0, 2));
            model(f, ew, m_done, m_err, m_wl);
            check_writes($sformatf("rnd%0d", fr), ew);
            check_flags($sformatf("rnd%0d", fr), m_done, m_err, m_wl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
